// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end (fetch stage and its buffer).
package mips_pkg;

    localparam int          PC_W        = 32;
    localparam int          INSTR_W     = 32;
    localparam int          IMEM_ADDR_W = 8;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    // Fetch buffer occupancy; the value doubles as the entry count used by the credit rule.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {pc, instr} FIFO between the instruction RAM and decode.
// The head entry is a dedicated register that drives the outputs directly;
// the second entry only absorbs a word when decode stalls.
module fetch_skid_buf #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              enq,
    input  logic [PC_W-1:0]   enq_pc,
    input  logic [DATA_W-1:0] enq_instr,
    input  logic              deq,
    output logic [1:0]        occ,
    output logic              head_valid,
    output logic [PC_W-1:0]   head_pc,
    output logic [DATA_W-1:0] head_instr
);

    mips_pkg::occ_e    occ_r;
    mips_pkg::occ_e    occ_nxt_s;
    logic              valid_r;
    logic [PC_W-1:0]   head_pc_r;
    logic [DATA_W-1:0] head_instr_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [DATA_W-1:0] skid_instr_r;
    logic              head_from_in_s;
    logic              head_from_skid_s;
    logic              skid_load_s;

    assign occ        = occ_r;
    assign head_valid = valid_r;
    assign head_pc    = head_pc_r;
    assign head_instr = head_instr_r;

    // Next occupancy and which registers move on this edge.
    always_comb begin
        occ_nxt_s        = occ_r;
        head_from_in_s   = 1'b0;
        head_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        case (occ_r)
            mips_pkg::OCC_EMPTY: begin
                if (enq) begin
                    occ_nxt_s      = mips_pkg::OCC_ONE;
                    head_from_in_s = 1'b1;
                end else begin
                    occ_nxt_s = mips_pkg::OCC_EMPTY;
                end
            end
            mips_pkg::OCC_ONE: begin
                if (enq && deq) begin
                    head_from_in_s = 1'b1;
                end else if (enq) begin
                    occ_nxt_s   = mips_pkg::OCC_FULL;
                    skid_load_s = 1'b1;
                end else if (deq) begin
                    occ_nxt_s = mips_pkg::OCC_EMPTY;
                end else begin
                    occ_nxt_s = mips_pkg::OCC_ONE;
                end
            end
            mips_pkg::OCC_FULL: begin
                if (enq && deq) begin
                    head_from_skid_s = 1'b1;
                    skid_load_s      = 1'b1;
                end else if (deq) begin
                    occ_nxt_s        = mips_pkg::OCC_ONE;
                    head_from_skid_s = 1'b1;
                end else begin
                    occ_nxt_s = mips_pkg::OCC_FULL;
                end
            end
            default: begin
                occ_nxt_s = mips_pkg::OCC_EMPTY;
            end
        endcase
    end

    // Occupancy, valid flag and entry storage; flush drops contents but keeps stale data bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r        <= mips_pkg::OCC_EMPTY;
            valid_r      <= 1'b0;
            head_pc_r    <= {PC_W{1'b0}};
            head_instr_r <= DATA_W'(mips_pkg::NOP_INSTR);
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= DATA_W'(mips_pkg::NOP_INSTR);
        end else if (flush) begin
            occ_r   <= mips_pkg::OCC_EMPTY;
            valid_r <= 1'b0;
        end else begin
            occ_r   <= occ_nxt_s;
            valid_r <= (occ_nxt_s != mips_pkg::OCC_EMPTY);
            if (head_from_in_s) begin
                head_pc_r    <= enq_pc;
                head_instr_r <= enq_instr;
            end else if (head_from_skid_s) begin
                head_pc_r    <= skid_pc_r;
                head_instr_r <= skid_instr_r;
            end
            if (skid_load_s) begin
                skid_pc_r    <= enq_pc;
                skid_instr_r <= enq_instr;
            end
        end
    end

endmodule

// File: rtl/ifetch_unit_chk.sv
// Invariant checker for the fetch stage buffer: the credit rule must keep the
// two-entry buffer from ever overflowing or reaching an illegal occupancy.
module ifetch_unit_chk
    import mips_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic       flush,
    input logic       enq,
    input logic       deq,
    input logic [1:0] occ
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(enq && !deq && !flush && (occ == OCC_FULL)));

    a_occ_legal: assert property (@(posedge clk) disable iff (rst)
        (occ != 2'd3));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word addresses to the 1-cycle
// instruction RAM under a two-entry credit limit, captures returned words into
// the skid buffer and handles redirect/flush and RAM port lending.
module ifetch_unit #(
    parameter int                ADDR_W   = mips_pkg::IMEM_ADDR_W,
    parameter int                DATA_W   = mips_pkg::INSTR_W,
    parameter int                PC_W     = mips_pkg::PC_W,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(mips_pkg::RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [PC_W-1:0]   if_pc,
    input  logic              id_ready
);

    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(2'd3);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] inflight_pc_r;
    logic            inflight_r;
    logic [1:0]      occ_s;
    logic            deq_s;
    logic            enq_s;
    logic            issue_s;
    logic            credit_ok_s;

    assign mem_addr = pc_r[ADDR_W+1:2];
    assign deq_s    = if_valid & id_ready;

    // Buffered + in-flight words, less the one decode takes this cycle, must leave room for one more.
    assign credit_ok_s = ({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, deq_s});
    assign issue_s     = ~redir_valid & mem_gnt & credit_ok_s;

    // A word returning during a redirect belongs to the old path and is discarded.
    assign enq_s = inflight_r & ~redir_valid;

    // PC, in-flight flag and PC of the outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC & ALIGN_MASK;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {PC_W{1'b0}};
        end else if (redir_valid) begin
            pc_r       <= redir_pc & ALIGN_MASK;
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            pc_r          <= pc_r + PC_W'(3'd4);
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redir_valid),
        .enq        (enq_s),
        .enq_pc     (inflight_pc_r),
        .enq_instr  (mem_q),
        .deq        (deq_s),
        .occ        (occ_s),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    ifetch_unit_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (redir_valid),
        .enq   (enq_s),
        .deq   (deq_s),
        .occ   (occ_s)
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: two instances (RESET_PC 0 and 0x3F8) each in front of a
// 1-cycle RAM model holding mem[i]=i. Stimulus pushes expected {pc,instr} into a
// queue; a negedge monitor pops and compares on every decode handshake.
module tb_ifetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, mem_gnt, redir_valid, id_ready;
    logic [31:0] redir_pc;
    logic [7:0]  mem_addr;
    logic [31:0] mem_q = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;

    logic        rst_b, mem_gnt_b;
    logic        redir_valid_b = 1'b0;
    logic [31:0] redir_pc_b = 32'h0;
    logic        id_ready_b = 1'b1;
    logic [7:0]  mem_addr_b;
    logic [31:0] mem_q_b = 32'h0;
    logic        if_valid_b;
    logic [31:0] if_instr_b, if_pc_b;

    logic [31:0] mem [0:255];
    exp_t        exp_q[$];
    exp_t        exp_b_q[$];
    exp_t        mon_e, mon_eb;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_q(mem_q),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
    );

    ifetch_unit #(.RESET_PC(32'h0000_03F8)) dut_b (
        .clk(clk), .rst(rst_b), .mem_addr(mem_addr_b), .mem_gnt(mem_gnt_b), .mem_q(mem_q_b),
        .redir_valid(redir_valid_b), .redir_pc(redir_pc_b), .if_valid(if_valid_b),
        .if_instr(if_instr_b), .if_pc(if_pc_b), .id_ready(id_ready_b)
    );

    // RAM models: registered read, address ignored when the port is not granted.
    always @(posedge clk) begin
        if (mem_gnt) mem_q <= mem[mem_addr];
        if (mem_gnt_b) mem_q_b <= mem[mem_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (if_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra: got pc %h instr %h expected nothing", if_pc, if_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", if_pc, mon_e.pc);
                check("sb_instr", if_instr, mon_e.instr);
            end
        end
        if (if_valid_b === 1'b1 && id_ready_b === 1'b1) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_b_extra: got pc %h instr %h expected nothing", if_pc_b, if_instr_b);
            end else begin
                mon_eb = exp_b_q.pop_front();
                check("sb_b_pc", if_pc_b, mon_eb.pc);
                check("sb_b_instr", if_instr_b, mon_eb.instr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
        rst = 1'b1; mem_gnt = 1'b1; id_ready = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0;
        rst_b = 1'b1; mem_gnt_b = 1'b0;
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_b_mem_addr", 32'(mem_addr_b), 32'hFE);
        step();

        // 1: streaming from reset, 8 granted issues
        for (int k = 0; k < 8; k++) push(32'(k * 4), 32'(k));
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            mem_gnt = (c < 8);
            @(negedge clk);
            if (c < 2) check("t1_latency_low", 32'(if_valid), 32'h0);
            if (c >= 2 && c < 10) check("t1_stream_valid", 32'(if_valid), 32'h1);
            if (c == 2) check("t1_first_pc", if_pc, 32'h0);
            if (c == 10) check("t1_end_low", 32'(if_valid), 32'h0);
            step();
        end
        check("t1_drain", 32'(exp_q.size()), 32'h0);

        // 2: decode stall for 5 cycles
        for (int k = 0; k < 5; k++) push(32'h20 + 32'(k * 4), 32'(8 + k));
        for (int c = 0; c < 15; c++) begin
            id_ready = !(c >= 3 && c <= 7);
            mem_gnt  = (c <= 9);
            @(negedge clk);
            if (c >= 3 && c <= 7) begin
                check("t2_stall_valid", 32'(if_valid), 32'h1);
                check("t2_stall_pc", if_pc, 32'h24);
                check("t2_stall_instr", if_instr, 32'h9);
            end
            if (c >= 4 && c <= 7) check("t2_no_issue_addr", 32'(mem_addr), 32'h0B);
            step();
        end
        check("t2_drain", 32'(exp_q.size()), 32'h0);

        // 3: redirect to 0x43 with a word in flight and one buffered
        push(32'h34, 32'h0D);
        push(32'h40, 32'h10);
        push(32'h44, 32'h11);
        for (int c = 0; c < 10; c++) begin
            mem_gnt     = (c <= 4);
            redir_valid = (c == 2);
            redir_pc    = 32'h43;
            @(negedge clk);
            if (c == 2) check("t3_deq_in_redir", if_pc, 32'h34);
            if (c == 3 || c == 4) check("t3_flushed", 32'(if_valid), 32'h0);
            if (c == 5) begin
                check("t3_valid", 32'(if_valid), 32'h1);
                check("t3_pc", if_pc, 32'h40);
                check("t3_instr", if_instr, 32'h10);
            end
            step();
        end
        check("t3_drain", 32'(exp_q.size()), 32'h0);

        // 4: redirect to 0, then grant toggling 1,0,1,0
        push(32'h0, 32'h0);
        push(32'h4, 32'h1);
        push(32'h8, 32'h2);
        for (int c = 0; c < 10; c++) begin
            redir_valid = (c == 0);
            redir_pc    = 32'h0;
            mem_gnt     = (c == 1 || c == 3 || c == 5);
            @(negedge clk);
            if (c == 3) check("t4_first_pc", if_pc, 32'h0);
            if (c == 4) check("t4_gap", 32'(if_valid), 32'h0);
            step();
        end
        check("t4_drain", 32'(exp_q.size()), 32'h0);

        // 6: reset with buffered and in-flight words; nothing stale afterwards
        push(32'h0, 32'h0);
        push(32'h4, 32'h1);
        for (int c = 0; c < 13; c++) begin
            id_ready = (c > 2);
            rst      = (c == 2);
            mem_gnt  = (c <= 1) || (c == 7) || (c == 8);
            @(negedge clk);
            if (c == 2) check("t6_pre_rst_pc", if_pc, 32'hC);
            if (c >= 3 && c <= 8) check("t6_no_stale", 32'(if_valid), 32'h0);
            if (c == 3) check("t6_pc_reset", 32'(mem_addr), 32'h0);
            if (c == 9) check("t6_restart_pc", if_pc, 32'h0);
            step();
        end
        check("t6_drain", 32'(exp_q.size()), 32'h0);

        // 5: address wrap from RESET_PC 0x3F8
        exp_b_q.push_back({32'h3F8, 32'hFE});
        exp_b_q.push_back({32'h3FC, 32'hFF});
        exp_b_q.push_back({32'h400, 32'h00});
        rst_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            mem_gnt_b = (c <= 2);
            @(negedge clk);
            if (c == 0) check("t5_addr0", 32'(mem_addr_b), 32'hFE);
            if (c == 1) check("t5_addr1", 32'(mem_addr_b), 32'hFF);
            if (c == 2) begin
                check("t5_addr2", 32'(mem_addr_b), 32'h00);
                check("t5_first_pc", if_pc_b, 32'h3F8);
            end
            step();
        end
        check("t5_drain", 32'(exp_b_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
